// File: rtl/lpc_stream_arbiter.sv
//------------------------------------------------------------------------------
// lpc_stream_arbiter
//
// Frame-locked round-robin arbiter. It shares the single 81-bit AXI-Stream
// sample output of the LPC encoder among N encoder channels. A channel keeps
// the grant until it sends a beat with a nonzero last code. A channel also
// loses the grant when it reaches MAX_BEATS beats in one frame; in that case
// the sticky overrun flag is raised. flush aborts the current frame at once.
//
// Ports
//   ACLK, ARESET_N   clock, asynchronous active-low reset
//   req_valid[N]     per-channel sample valid
//   req_data[81*N]   channel i sample at [81*i +: 81]
//   req_last[4*N]    channel i last code at [4*i +: 4]; nonzero = final beat
//   req_ready[N]     per-channel accept (only the granted bit can be high)
//   out_sample/out_valid/out_last/out_ready
//                    master sample port, pass-through from the granted channel
//   flush            synchronous abort; returns to IDLE and clears err_overrun
//   grant_id         granted channel in GRANT, last granted channel in IDLE
//   busy             1 while in GRANT
//   err_overrun      sticky; a frame was cut at MAX_BEATS beats
//------------------------------------------------------------------------------
module lpc_stream_arbiter #(
    parameter int N         = 4,
    parameter int MAX_BEATS = 256
) (
    input  logic             ACLK,
    input  logic             ARESET_N,
    input  logic [N-1:0]     req_valid,
    input  logic [81*N-1:0]  req_data,
    input  logic [4*N-1:0]   req_last,
    output logic [N-1:0]     req_ready,
    output logic [80:0]      out_sample,
    output logic             out_valid,
    output logic [3:0]       out_last,
    input  logic             out_ready,
    input  logic             flush,
    output logic [2:0]       grant_id,
    output logic             busy,
    output logic             err_overrun
);

    localparam int          GW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [15:0] LAST_CNT = 16'(MAX_BEATS - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state;
    logic [2:0]  grant;
    logic [2:0]  last_grant;
    logic [15:0] beat_cnt;

    // Unpack the flat channel buses so the data mux can use a plain index.
    logic [80:0] ch_sample [N];
    logic [3:0]  ch_last   [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign ch_sample[i] = req_data[81*i +: 81];
        assign ch_last[i]   = req_last[4*i +: 4];
    end

    logic [GW-1:0] g_idx;
    assign g_idx = grant[GW-1:0];

    // Channel index 'offset' positions after 'base', with wrap-around at N.
    function automatic logic [GW-1:0] rr_index(input logic [2:0] base, input int offset);
        return GW'((int'(base) + offset) % N);
    endfunction

    // Round-robin pick: the first requester after last_grant, with wrap-around.
    logic [GW-1:0] pick;
    logic          pick_found;

    // NOTE: every signal written in always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!pick_found && req_valid[rr_index(last_grant, i)]) begin
                pick       = rr_index(last_grant, i);
                pick_found = 1'b1;
            end
        end
    end

    // Zero-latency pass-through from the granted channel. flush blocks the
    // handshake so that no beat is accepted in the abort cycle.
    always_comb begin
        out_sample = '0;
        out_last   = '0;
        out_valid  = 1'b0;
        req_ready  = '0;
        if (state == GRANT) begin
            out_sample = ch_sample[g_idx];
            out_last   = ch_last[g_idx];
            if (!flush) begin
                out_valid        = req_valid[g_idx];
                req_ready[g_idx] = out_ready;
            end
        end
    end

    logic accept, frame_end, overrun;
    assign accept    = out_valid && out_ready;
    assign frame_end = accept && (out_last != 4'd0);
    // A real frame end on the limit beat has priority, so overrun is not raised then.
    assign overrun   = accept && (out_last == 4'd0) && (beat_cnt == LAST_CNT);

    // NOTE: state registers are updated with non-blocking assignments only.
    // Every register reads its pre-edge value, whatever the statement order.
    always_ff @(posedge ACLK or negedge ARESET_N) begin
        if (!ARESET_N) begin
            state       <= IDLE;
            grant       <= '0;
            last_grant  <= 3'(N - 1);   // channel 0 wins the first arbitration
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
        end else if (flush) begin
            if (state == GRANT)
                last_grant <= grant;
            state       <= IDLE;
            beat_cnt    <= '0;
            err_overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant    <= 3'(pick);
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (accept) begin
                        if (frame_end || overrun) begin
                            state      <= IDLE;
                            last_grant <= grant;
                            beat_cnt   <= '0;
                        end else begin
                            beat_cnt <= beat_cnt + 16'd1;
                        end
                        if (overrun)
                            err_overrun <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == GRANT);
    assign grant_id = (state == GRANT) ? grant : last_grant;

endmodule

// File: doc/lpc_stream_arbiter.md
# lpc_stream_arbiter

Frame-locked round-robin arbiter that shares the single 81-bit AXI-Stream master output of the LPC encoder between N encoder channels. Each channel presents samples with a 4-bit last code. The arbiter grants one channel at a time, holds the grant until that channel's frame ends, and forwards beats to the sample port of the AXI-S master interface (SAMPLE/VALID_SAMPLE/READY/LAST). It also enforces a per-frame beat limit and handles flush requests.

## Interface
Parameters:
- N, 4, number of requesting channels (2..8)
- MAX_BEATS, 256, maximum beats per frame before forced release (1..65535)

Ports:
- ACLK  in  1  clock; all logic on rising edge
- ARESET_N  in  1  reset, asynchronous, active-low
- req_valid  in  N  per-channel sample valid
- req_data  in  81*N  channel i sample at [81*i+80 : 81*i]
- req_last  in  4*N  channel i last code at [4*i+3 : 4*i]; nonzero marks the final beat of a frame
- req_ready  out  N  per-channel accept
- out_sample  out  81  to master SAMPLE
- out_valid  out  1  to master VALID_SAMPLE
- out_last  out  4  to master LAST
- out_ready  in  1  from master READY
- flush  in  1  synchronous abort (driven by the same TUSER as the master)
- grant_id  out  3  currently or last granted channel
- busy  out  1  1 while in GRANT
- err_overrun  out  1  sticky; a frame exceeded MAX_BEATS

## Operation
- States: IDLE, GRANT. Registers: state, grant (3b), last_grant (3b), beat_cnt (16b), err_overrun.
- IDLE: out_valid=0 and req_ready=0. If any req_valid is set, select the first set bit scanning from (last_grant+1) mod N upward with wrap. Register grant and move to GRANT. With no request, stay in IDLE.
- GRANT, granted channel g:
  - out_sample/out_valid/out_last are driven combinationally from channel g.
  - req_ready[g] = out_ready; all other req_ready bits are 0.
- A beat is accepted when out_valid && out_ready. Each accepted beat increments beat_cnt.
- Frame end: an accepted beat with out_last != 0. Next state is IDLE, last_grant=g, beat_cnt=0.
- Overrun: an accepted beat with out_last == 0 and beat_cnt == MAX_BEATS-1.
  - Same as frame end: IDLE, last_grant=g, beat_cnt=0.
  - err_overrun is set to 1. The rest of the frame is delivered under a later grant of the same channel as a new frame.
- Frame end and overrun on the same beat: treat as frame end; err_overrun is not set.
- flush=1 has priority over everything:
  - Next state IDLE, beat_cnt=0, err_overrun cleared.
  - last_grant is set to the current grant if in GRANT, otherwise unchanged.
  - While flush=1, out_valid=0 and all req_ready=0, so no beat is accepted in that cycle.
- If req_valid[g] drops mid-frame, the arbiter holds the grant and waits. There is no timeout.
- grant_id shows grant in GRANT and last_grant in IDLE. busy = (state==GRANT).

## Timing
- Reset values:
  - state=IDLE, last_grant=N-1 (channel 0 wins first), grant=0, beat_cnt=0, err_overrun=0.
  - Outputs: out_valid=0, out_sample=0, out_last=0, req_ready=0, busy=0, grant_id=N-1.
- Outside GRANT, out_sample and out_last are 0.
- Arbitration latency: a request seen in IDLE at cycle t gives GRANT with out_valid at t+1.
- Inter-frame bubble: last beat accepted at t, IDLE at t+1, next grant at t+2. There is exactly one idle cycle between frames.
- Datapath latency in GRANT is 0 cycles (pass-through). The master's READY deasserts for one cycle after each accepted beat, so sustained throughput is one beat per two cycles.
- Reset assertion mid-frame forces all reset values immediately, asynchronously. The partial frame is dropped.

## Test plan
- Reset, then only ch2 valid with 3 beats, last=0,0,1, out_ready=1 -> grant_id=2 and busy=1 one cycle after req; 3 beats forwarded in order; IDLE after the last beat; grant_id stays 2.
- Channels 0..3 all valid with continuous 1-beat frames (last=1) -> grant order 0,1,2,3,0,1; one idle cycle between grants.
- ch1 frame of 4 beats, out_ready held 0 for 5 cycles after beat 2 -> out_sample/out_valid stable, req_ready[1]=0 throughout, no beat lost or duplicated, all 4 beats delivered.
- MAX_BEATS=4, ch0 sends 6 beats with last=0 while ch1 waits -> release after beat 4, err_overrun=1, ch1 granted next, then ch0 granted again for the remaining beats.
- flush=1 mid-frame on ch3 after an overrun -> next cycle IDLE, err_overrun=0, no accepted beat while flush=1; after flush drops, ch0 (next after 3) wins if requesting.
- ARESET_N low mid-frame for 1 cycle -> all outputs at reset values during reset; afterwards ch0 has first priority.
